mul_accumulator: RTL
====================

MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

Interface
- REQ-001 SHALL have parameter ACC_WIDTH, default 16: accumulator and result width in bits; legal range 9..32.
- REQ-002 SHALL have parameter LEN_WIDTH, default 8: width of the product-count field.
- REQ-003 SHALL have port Clock, input, 1: single clock; all state updates on its rising edge.
- REQ-004 SHALL have port Reset, input, 1: synchronous, active-low reset, sampled on the rising edge of Clock.
- REQ-005 SHALL have port iStart, input, 1: begin a new accumulation run.
- REQ-006 SHALL have port iLength, input, LEN_WIDTH: number of products in the run, sampled only when a start is accepted.
- REQ-007 SHALL have port iValid, input, 1: iProduct holds a valid product this cycle.
- REQ-008 SHALL have port iProduct, input, 8: unsigned product from the 4x4 multiplier stage.
- REQ-009 SHALL have port oReady, output, 1: block accepts a product this cycle.
- REQ-010 SHALL have port oBusy, output, 1: a run is in progress.
- REQ-011 SHALL have port oDone, output, 1: single-cycle pulse at the end of a run.
- REQ-012 SHALL have port oOverflow, output, 1: the current or last run saturated.
- REQ-013 SHALL have port oResult, output, ACC_WIDTH: accumulated sum.

Function
- REQ-014 SHALL implement three states: IDLE, ACC, DONE.
- REQ-015 In IDLE, SHALL drive oReady=0, oBusy=0, oDone=0, and hold oResult and oOverflow.
- REQ-016 In IDLE with iStart=1, SHALL latch iLength, clear the accumulator, clear oOverflow and the product counter, and go to ACC next cycle.
- REQ-017 In IDLE with iStart=1 and iLength=0, SHALL instead go directly to DONE with oResult=0.
- REQ-018 In ACC, SHALL drive oReady=1 and oBusy=1.
- REQ-019 In ACC, a product SHALL be accepted only on a cycle with iValid=1 and oReady=1; cycles with iValid=0 SHALL leave all state unchanged.
- REQ-020 On acceptance, SHALL set acc <= acc + zero-extended iProduct and increment the counter, with the result visible on oResult the next cycle (1-cycle latency).
- REQ-021 If the full-precision sum exceeds 2^ACC_WIDTH-1, SHALL hold acc at 2^ACC_WIDTH-1 and set oOverflow=1, which stays set until the next accepted start or reset.
- REQ-022 On accepting the product that makes the count equal to the latched length, SHALL go to DONE next cycle; no further products SHALL be accepted.
- REQ-023 In DONE, SHALL drive oDone=1 and oBusy=0 for exactly one cycle, oReady=0, and oResult equal to the final sum; next state SHALL be IDLE unconditionally.
- REQ-024 SHALL ignore iStart in ACC and in DONE; a start is accepted only in IDLE.
- REQ-025 SHALL keep the counter LEN_WIDTH bits wide so that it never wraps below the latched length; iLength = 2^LEN_WIDTH-1 SHALL be a legal maximum.
- REQ-026 SHALL produce no combinational path from iValid or iProduct to any output; all outputs SHALL be registered or decoded from state.

Reset
- REQ-027 While Reset=0 at a rising edge, SHALL enter IDLE and set oResult=0, oOverflow=0, oDone=0, oReady=0, oBusy=0, and the counter and latched length to 0.
- REQ-028 Reset asserted mid-run SHALL abort the run with no oDone pulse; the first iStart after Reset deasserts SHALL start normally.

Verification
- REQ-029 Basic run: iStart with iLength=3, products 0x0F, 0xE1, 0x01 on consecutive cycles -> oResult=0x00F1, oDone high for exactly 1 cycle, oOverflow=0.
- REQ-030 Gaps: iLength=2, iValid pattern 1,0,0,1 with products 0x10 and 0x20 -> oResult=0x0030; the idle cycles change nothing.
- REQ-031 Saturation with ACC_WIDTH=10: iLength=5, five products of 0xE1 (sum 1125) -> oResult=0x3FF and oOverflow=1; the next start clears oOverflow.
- REQ-032 Zero length: iStart with iLength=0 -> DONE on the next cycle, oResult=0, oReady never asserted.
- REQ-033 Maximum length: iLength=255 with all products 0xE1 -> oResult=57375 (0xE01F), oOverflow=0, and exactly 255 accepts.
- REQ-034 Reset and ignored start: assert Reset after 2 of 4 products -> all outputs 0 with no oDone pulse; separately, iStart held during ACC -> count and sum unaffected.

Source files
------------

// File: rtl/mul_accumulator_if.sv
// Handshake and result bundle for the product accumulator.
// The source side drives runs and products; the accumulator side reports status and the sum.
interface mul_accumulator_if #(
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 8
);
  logic                 iStart;
  logic [LEN_WIDTH-1:0] iLength;
  logic                 iValid;
  logic [7:0]           iProduct;
  logic                 oReady;
  logic                 oBusy;
  logic                 oDone;
  logic                 oOverflow;
  logic [ACC_WIDTH-1:0] oResult;

  modport master (
    output iStart, iLength, iValid, iProduct,
    input  oReady, oBusy, oDone, oOverflow, oResult
  );

  modport slave (
    input  iStart, iLength, iValid, iProduct,
    output oReady, oBusy, oDone, oOverflow, oResult
  );
endinterface

// File: rtl/mul_accumulator.sv
// Saturating accumulator for a run of 8-bit products from a 4x4 multiplier stage.
// IDLE -> ACC -> DONE sequencing; every output comes straight from a register.
module mul_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input logic Clock,
  input logic Reset,
  mul_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ovf;

  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [LEN_WIDTH-1:0] w_cnt_next;
  logic                 w_accept;
  logic                 w_last;

  // Full-precision sum with one carry bit; the carry marks saturation.
  always_comb begin
    w_sum      = {1'b0, r_acc} + {{(ACC_WIDTH-7){1'b0}}, bus.iProduct};
    w_cnt_next = r_cnt + LEN_WIDTH'(1);
    w_accept   = r_ready & bus.iValid;
    w_last     = (w_cnt_next == r_len);
    if (w_sum[ACC_WIDTH]) begin
      w_acc_next = {ACC_WIDTH{1'b1}};
    end else begin
      w_acc_next = w_sum[ACC_WIDTH-1:0];
    end
  end

  // Run sequencer; status flags are registered alongside the next state.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_acc   <= {ACC_WIDTH{1'b0}};
      r_len   <= {LEN_WIDTH{1'b0}};
      r_cnt   <= {LEN_WIDTH{1'b0}};
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.iStart) begin
            r_len <= bus.iLength;
            r_acc <= {ACC_WIDTH{1'b0}};
            r_cnt <= {LEN_WIDTH{1'b0}};
            r_ovf <= 1'b0;
            if (bus.iLength == {LEN_WIDTH{1'b0}}) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ACC;
              r_ready <= 1'b1;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ACC: begin
          // iStart is deliberately ignored while a run is open.
          if (w_accept) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_sum[ACC_WIDTH];
            r_cnt <= w_cnt_next;
            if (w_last) begin
              r_state <= DONE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ACC;
            end
          end else begin
            r_state <= ACC;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oReady    = r_ready;
  assign bus.oBusy     = r_busy;
  assign bus.oDone     = r_done;
  assign bus.oOverflow = r_ovf;
  assign bus.oResult   = r_acc;

endmodule
